// File: rtl/tc_uart_io.sv
// tc_uart_io: TinyComp serial I/O responder, one 8N1 UART channel behind the CPU Input/Output interface
// Ports: Ph0 clock, Reset async active-high; OutStrobe/OutData push a byte into the TX FIFO;
// InStrobe acknowledges the RX byte; InData = {21'b0, FrameErr, TxFull, Overrun, RxByte};
// InRdy flags an unread RX byte; RxD serial in (async), TxD serial out (idle high).
module tc_uart_io #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic        Ph0,
  input  logic        Reset,
  input  logic        OutStrobe,
  input  logic [31:0] OutData,
  input  logic        InStrobe,
  output logic [31:0] InData,
  output logic        InRdy,
  input  logic        RxD,
  output logic        TxD
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TXFIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st, rx_st;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_sh, rx_sh, rx_byte;
  logic [7:0] mem [TXFIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic rx_s1, rx_s, rx_armed, overrun, frame_err;
  logic empty, full, pop, push, tx_end, rx_samp;
  logic unused_out;
  assign unused_out = ^OutData[31:8];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_end = tx_cnt == LAST;
  // a pop frees the slot being written, so a full FIFO still accepts a byte then
  assign pop = !empty && (tx_st == IDLE || (tx_st == STOP && tx_end));
  assign push = OutStrobe && (!full || pop);
  assign rx_samp = rx_cnt == (rx_st == START ? MID : LAST);
  assign InData = {21'b0, frame_err, full, overrun, rx_byte};
  always_ff @(posedge Ph0)
    if (push) mem[wr_ptr[AW-1:0]] <= OutData[7:0];
  always_ff @(posedge Ph0 or posedge Reset)
    if (Reset) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      TxD <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // TxD is registered from the current state, so it lags the FSM by one cycle
      TxD <= tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
      tx_cnt <= (tx_st == IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
      if (pop) begin
        tx_sh <= mem[rd_ptr[AW-1:0]];
        tx_st <= START;
      end else if (tx_end)
        case (tx_st)
          START: begin
            tx_st <= DATA;
            tx_bit <= '0;
          end
          DATA: begin
            tx_sh <= tx_sh >> 1;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_st <= STOP;
          end
          STOP: tx_st <= IDLE;
          default: tx_st <= IDLE;
        endcase
    end
  always_ff @(posedge Ph0 or posedge Reset)
    if (Reset) begin
      rx_s1 <= 1'b0;
      rx_s <= 1'b0;
      rx_armed <= 1'b0;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_byte <= '0;
      InRdy <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1 <= RxD;
      rx_s <= rx_s1;
      rx_cnt <= (rx_st == IDLE || rx_samp) ? '0 : rx_cnt + 1'b1;
      // a line held low across reset release must not look like a start bit
      if (rx_s) rx_armed <= 1'b1;
      if (InStrobe) begin
        InRdy <= 1'b0;
        overrun <= 1'b0;
        frame_err <= 1'b0;
      end
      case (rx_st)
        IDLE: if (rx_armed && !rx_s) rx_st <= START;
        START: if (rx_samp) begin
          rx_st <= rx_s ? IDLE : DATA;
          rx_bit <= '0;
        end
        DATA: if (rx_samp) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= STOP;
        end
        STOP: if (rx_samp) begin
          rx_st <= IDLE;
          if (!rx_s) frame_err <= 1'b1;
          else if (!InRdy || InStrobe) begin
            rx_byte <= rx_sh;
            InRdy <= 1'b1;
          end else overrun <= 1'b1;
        end
        default: rx_st <= IDLE;
      endcase
    end
endmodule

// File: doc/tc_uart_io.md
# tc_uart_io

Serial I/O responder for the TinyComp CPU. It sits on the far side of the CPU's Input/Output instruction interface. It supplies `InData`/`InRdy` from a UART receiver and consumes `OutStrobe` bytes into a small transmit FIFO that drains through a UART transmitter. This gives the CPU one byte-wide 8N1 serial channel, pollable with its skip-on-`InRdy` test.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: Ph0 cycles per serial bit, ≥ 4; 115200 baud at 100 MHz.
- `TXFIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥ 2.

Ports:
- `Ph0`, in, 1: sole clock, rising edge. Same clock as the CPU PC register.
- `Reset`, in, 1: asynchronous, active-high; clears all state.
- `OutStrobe`, in, 1: CPU executing an Output instruction; one Ph0 cycle per instruction.
- `OutData`, in, 32: CPU output value; only [7:0] is used and is sampled when `OutStrobe`=1.
- `InStrobe`, in, 1: CPU executing an Input instruction; one cycle; acknowledges the receive byte.
- `InData`, out, 32: {21'b0, FrameErr, TxFull, Overrun, RxByte[7:0]}, i.e. [10]=FrameErr, [9]=TxFull, [8]=Overrun.
- `InRdy`, out, 1: receive holding register holds an unread byte.
- `RxD`, in, 1: serial input, asynchronous to Ph0, idle high.
- `TxD`, out, 1: serial output, idle high.

## Operation
- Reset values: `TxD`=1, `InRdy`=0, `InData`=0, FIFO empty, both FSMs IDLE.
- TX FIFO write:
  - `OutStrobe`=1 pushes `OutData[7:0]` if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is silently dropped.
  - `TxFull` (InData[9]) is combinational from the FIFO count == `TXFIFO_DEPTH`.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE with FIFO non-empty: pop the head into the shift register and enter START.
  - START drives 0; DATA drives 8 bits, LSB first; STOP drives 1. Each bit lasts `CLKS_PER_BIT` cycles.
  - At the end of STOP with FIFO non-empty: pop and go directly to START, with no idle gap.
- RX synchronizer: `RxD` passes through two Ph0 flops. All RX logic uses the synchronized value.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized 0 enters START.
  - START: samples at `CLKS_PER_BIT/2` (integer division). If the sample is 1 (glitch), return to IDLE with no flags set.
  - DATA: 8 samples spaced `CLKS_PER_BIT` apart, LSB first.
  - STOP: one sample `CLKS_PER_BIT` after the last data sample, then IDLE.
- Byte completion at the stop sample:
  - Stop=0: byte discarded; FrameErr set.
  - Stop=1, holding register empty, or `InStrobe` in the same cycle: load RxByte, `InRdy`=1.
  - Stop=1, holding register full, no `InStrobe`: new byte discarded; Overrun set; old byte kept.
- `InStrobe`=1:
  - Clears `InRdy`, Overrun and FrameErr on that edge, unless the same edge loads a new byte, in which case `InRdy` stays 1.
  - `InStrobe` with `InRdy`=0 is legal: it clears the sticky flags, and `InData` reads the stale RxByte.
- RxByte holds its last value after being read. It is never cleared except by `Reset`.

## Timing
- `OutStrobe` sampled at edge n with TX IDLE and FIFO empty:
  - push at n; pop at n+1; `TxD` falls at n+2.
  - Frame is 10×`CLKS_PER_BIT` cycles.
- Back-to-back bytes: the next start bit begins on the cycle after the last STOP cycle.
- RX: `InRdy` rises one edge after the stop-bit sample. The stop sample is about 9.5 bit times plus 2 synchronizer cycles after the `RxD` falling edge.
- `InData`/`InRdy` are registered, except `TxFull`, which is decoded from registered count.
- The CPU reads `InData` combinationally in the `InStrobe` cycle. The value must be stable for that whole cycle.
- `Reset` mid-frame:
  - `TxD`=1 immediately (asynchronous); the partial frame is truncated and the FIFO is emptied.
  - RX aborts; a partially received byte is lost.
  - After release, RX waits for a synchronized 1 before it accepts a start bit, so a mid-frame line does not false-start.
- Bit counters wrap only within an FSM state. Counters are sized ceil(log2(`CLKS_PER_BIT`)) bits; FIFO pointers are sized log2(`TXFIFO_DEPTH`)+1 bits.

## Test plan
(`CLKS_PER_BIT`=16, `TXFIFO_DEPTH`=4)
- Single TX: OutStrobe with OutData=0x000000A5 at edge 10.
  - `TxD`=0 over cycles 12–27.
  - Then 1,0,1,0,0,1,0,1, 16 cycles each.
  - Stop=1 until cycle 171; then idle high.
- FIFO full: 6 OutStrobes on consecutive cycles with bytes 0x01–0x06.
  - `TxFull`=1 after the 5th strobe (one entry popped).
  - Byte 0x06 is dropped.
  - Exactly 5 back-to-back frames, 0x01–0x05, with no gaps.
- RX normal: drive 8N1 0x3C on `RxD`.
  - `InRdy`=1 with InData=0x0000003C.
  - InStrobe → `InRdy`=0 next cycle; InData stays 0x3C.
- RX overrun/frame error: send 0x11 then 0x22 without InStrobe → InData=0x00000111, `InRdy`=1.
  - Then InStrobe → InData[8]=0.
  - Send 0x33 with stop bit 0 → `InRdy`=0, InData[10]=1.
- Glitch and reset:
  - 4-cycle low pulse on `RxD` → no `InRdy`, no flags.
  - Assert `Reset` mid-TX-frame → `TxD`=1 within the same cycle, FIFO empty, `InData`=0 after release.
